// File: rtl/halt_controller.sv
// Run/step/halt controller for the remote-lab CPU clock chain: debounces the
// board buttons, tracks the run mode, gates the clock reducer and counts slow cycles.
module halt_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        entrada,
    input  logic        reset_n,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_halt,
    input  logic        cpu_halt,
    input  logic        clk_lento,
    output logic        halt,
    output logic [1:0]  estado,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        PARADO  = 2'b00,
        RODANDO = 2'b01,
        PASSO   = 2'b10,
        FIM     = 2'b11
    } state_e;

    localparam int          BTN_RUN  = 0;
    localparam int          BTN_STEP = 1;
    localparam int          BTN_HALT = 2;
    localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);

    logic [2:0]  btn_s;
    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  lvl_q;
    logic [2:0]  lvl_d;
    logic [2:0]  lvl_prev_q;
    logic [2:0]  ev_q;
    logic [19:0] db_cnt_q [3];
    logic [19:0] db_cnt_d [3];
    logic        cpu_halt_q;
    logic        slow_q;
    logic        sl_rise_s;
    logic        active_s;
    state_e      state_q;
    state_e      state_d;
    logic        halt_q;
    logic        halt_d;
    logic [15:0] step_q;
    logic [15:0] step_d;

    assign btn_s     = {btn_halt, btn_step, btn_run};
    assign sl_rise_s = clk_lento & ~slow_q;
    assign active_s  = (state_q == RODANDO) || (state_q == PASSO);

    // Debounce counters: a level is accepted only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lvl_d[i]    = lvl_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i]    = ~lvl_q[i];
                    db_cnt_d[i] = 20'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 20'd1;
                end
            end else begin
                db_cnt_d[i] = 20'd0;
            end
        end
    end

    // Synchronizers, debounce state, press-event pulses and input registers.
    always_ff @(posedge entrada or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            lvl_q      <= 3'b000;
            lvl_prev_q <= 3'b000;
            ev_q       <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= 20'd0;
            end
            cpu_halt_q <= 1'b0;
            slow_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_s;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            ev_q       <= lvl_q & ~lvl_prev_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            cpu_halt_q <= cpu_halt;
            slow_q     <= clk_lento;
        end
    end

    // Mode next-state: cpu halt beats halt button beats run beats step; losers are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PARADO: begin
                if (ev_q[BTN_HALT]) begin
                    state_d = PARADO;
                end else if (ev_q[BTN_RUN]) begin
                    state_d = RODANDO;
                end else if (ev_q[BTN_STEP]) begin
                    state_d = PASSO;
                end else begin
                    state_d = PARADO;
                end
            end
            RODANDO: begin
                if (cpu_halt_q) begin
                    state_d = FIM;
                end else if (ev_q[BTN_HALT]) begin
                    state_d = PARADO;
                end else begin
                    state_d = RODANDO;
                end
            end
            PASSO: begin
                if (cpu_halt_q) begin
                    state_d = FIM;
                end else if (ev_q[BTN_HALT] || sl_rise_s) begin
                    state_d = PARADO;
                end else begin
                    state_d = PASSO;
                end
            end
            FIM:     state_d = FIM;
            default: state_d = PARADO;
        endcase

        halt_d = (state_d == PARADO) || (state_d == FIM);

        if (sl_rise_s && active_s) begin
            step_d = step_q + 16'd1;
        end else begin
            step_d = step_q;
        end
    end

    // Mode, reducer gate and slow-cycle counter registers.
    always_ff @(posedge entrada or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PARADO;
            halt_q  <= 1'b1;
            step_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            step_q  <= step_d;
        end
    end

    assign estado     = state_q;
    assign halt       = halt_q;
    assign step_count = step_q;

endmodule

// File: doc/halt_controller.md
# halt_controller

Run/step/halt controller for the remote-lab CPU clock chain. Sits directly upstream of the clock frequency reducer: it debounces the board pushbuttons, tracks the CPU run mode, and drives the reducer's `halt` input. It observes the reducer's slow clock output so that a single step releases exactly one slow-clock rising edge. It also counts executed slow cycles for display.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive board-clock samples a button must hold a new level before it is accepted. Legal range is 2 to 2^20-1.
- `entrada` in 1: board clock. This is the same clock that feeds the reducer.
- `reset_n` in 1: reset, asynchronous, active-low.
- `btn_run` in 1: raw pushbutton, active-high, asynchronous.
- `btn_step` in 1: raw pushbutton, active-high, asynchronous.
- `btn_halt` in 1: raw pushbutton, active-high, asynchronous.
- `cpu_halt` in 1: CPU has executed a halt instruction. It is level and stays high until CPU reset.
- `clk_lento` in 1: slow clock fed back from the reducer output. It is a registered signal in the `entrada` domain, so it needs no synchronizer.
- `halt` out 1: to the reducer. While high, the reducer holds its counter at 0.
- `estado` out 2: current state, used for LEDs.
- `step_count` out 16: slow-clock rising edges released since reset.

Clock is `entrada`. Reset is asynchronous and active-low (`reset_n`). There is one clock domain.

## Operation
- **Reset values.** `estado`=PARADO (2'b00), `halt`=1, `step_count`=0. All synchronizers, debouncers and edge registers clear to 0.
- **Per-button debounce path.**
  - The button first passes through a 2-flop synchronizer.
  - A counter then tracks the synchronized value:
    - If the synchronized value differs from the debounced level, the counter increments.
    - If it is equal, the counter clears.
    - On the edge where the counter would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Press event: a registered 1-cycle pulse, issued on the rising edge of the debounced level. There is no event on release.
- **cpu_halt** passes through 1 register (`cpu_halt_r`).
- **Slow-clock edge detect.** `clk_lento_d` registers `clk_lento`. The rise term `sl_rise = clk_lento & ~clk_lento_d` is combinational.
- **States.**
  - PARADO = 00
  - RODANDO = 01
  - PASSO = 10
  - FIM = 11
- **Transitions**, evaluated every edge with priority cpu_halt_r > halt_ev > run_ev > step_ev:
  - PARADO:
    - run_ev → RODANDO
    - step_ev → PASSO
    - cpu_halt_r is ignored here.
  - RODANDO:
    - cpu_halt_r → FIM
    - halt_ev → PARADO
    - run_ev and step_ev are ignored.
  - PASSO:
    - cpu_halt_r → FIM
    - halt_ev → PARADO
    - sl_rise → PARADO
    - run_ev and step_ev are ignored.
  - FIM: terminal. It is left only by `reset_n`.
- **halt output.** `halt` is 1 in PARADO and FIM, 0 in RODANDO and PASSO. It is registered together with `estado` and changes on the same edge.
- **step_count.** Increments by 1 on every edge where sl_rise=1 and the current state is RODANDO or PASSO. It wraps from 16'hFFFF to 0. It increments when sl_rise and a transition out of RODANDO/PASSO happen on the same edge. It does not increment in PARADO or FIM.
- **Simultaneous presses.** Events resolve by the priority above; lower-priority events on that edge are discarded, not queued.
- **Reset mid-operation.** Asynchronous return to reset values, including mid-debounce and mid-step.

## Timing
- **Button press to output.** A raw button held high from board edge k, with all other inputs quiet, produces its event pulse high during the cycle after edge k+DEBOUNCE_CYCLES+2. `estado` and `halt` update at edge k+DEBOUNCE_CYCLES+3.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- **cpu_halt.** When cpu_halt rises before edge j, `cpu_halt_r` is high after edge j, and FIM with `halt`=1 follows at edge j+1.
- **Single step.**
  - `halt` drops at edge s.
  - With the reducer's output on counter bit 13, `clk_lento` rises 8192 edges after s.
  - On the edge where sl_rise is seen, `estado` returns to PARADO, `halt`=1, and `step_count` increments.
  - Exactly one slow rising edge is released per step.
- **Edge-detect latency.** sl_rise is combinational from `clk_lento_d`, so there is no extra latency beyond 1 edge.

## Test plan
Use DEBOUNCE_CYCLES=4 and a behavioural reducer on bit 3 unless noted.
- **Reset.** Assert `reset_n`=0 mid-RODANDO → `estado`=00, `halt`=1, `step_count`=0 immediately, without waiting for a clock edge.
- **Debounce.**
  - Press `btn_run` for 3 cycles → no event, `estado`=00.
  - Hold it high instead → `estado`=01 and `halt`=0 exactly 7 edges after the first high sample.
- **Single step.**
  - Press `btn_step` from PARADO → `halt` low for exactly 8 edges, then `estado`=00, `halt`=1, `step_count`=1.
  - Repeat 3 presses → `step_count`=4.
- **Run then halt.**
  - Press run → `step_count` increments once per 16 edges.
  - Press `btn_halt` → `estado`=00 and `step_count` frozen.
- **CPU halt and priority.**
  - Raise `cpu_halt` in RODANDO → `estado`=11 two edges later.
  - Further run/step presses are ignored; only `reset_n` exits.
  - Press run and halt so both events land on the same edge in PARADO → `estado` stays 00.
- **Wrap.** Force `step_count` to 16'hFFFF in RODANDO → the next slow rise yields 0.
